// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared definitions: FSM state encoding,
// register map and field positions.
package irq_ctrl_pkg;

  // Values are visible in STAT[9:8]
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_INSVC = 2'd2
  } irq_state_t;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_EOI  = 2'd3;

  localparam int GEN_BIT   = 15;
  localparam int INSVC_BIT = 7;

  // (v + 1) mod n for 0 <= v < n
  function automatic int wrap_inc(
    input int v,
    input int n
  );
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/irq_arb.sv
// irq_arb: rotate-priority selector. Ports: req, ptr in;
// grant_valid, grant_idx out (first set req at/above ptr).
module irq_arb #(
  parameter int NSRC = 4,
  parameter int VW   = 3
) (
  input  logic [NSRC-1:0] req,
  input  logic [VW-1:0]   ptr,
  output logic            grant_valid,
  output logic [VW-1:0]   grant_idx
);

  logic [VW:0]     cand;
  logic [NSRC-1:0] sh;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    sh          = '0;
    for (int i = 0; i < NSRC; i++) begin
      cand = {1'b0, ptr} + (VW+1)'(i);
      if (cand >= (VW+1)'(NSRC))
        cand = cand - (VW+1)'(NSRC);
      sh = req >> cand;
      if (!grant_valid && sh[0]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[VW-1:0];
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller. Bus: sel/we/re/addr/wdata/
// rdata/rdy. Core: cpu_irq/cpu_vec/cpu_ack. Sources: irq_in.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC   = 4,
  parameter int ARB_RR = 0,
  parameter int VW     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sel,
  input  logic            we,
  input  logic            re,
  input  logic [1:0]      addr,
  input  logic [15:0]     wdata,
  output logic [15:0]     rdata,
  output logic            rdy,
  input  logic [NSRC-1:0] irq_in,
  output logic            cpu_irq,
  output logic [VW-1:0]   cpu_vec,
  input  logic            cpu_ack
);

  irq_state_t      st_q, st_nx;
  logic            gen_q;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] pend_sh;
  logic [VW-1:0]   vec_q, vec_nx;
  logic [VW-1:0]   ptr_q, ptr_nx;
  logic [VW-1:0]   arb_ptr;
  logic [VW-1:0]   gnt_idx;
  logic            gnt_valid;
  logic            irq_q, irq_nx;
  logic            cur_live;
  logic            ctrl_wr;
  logic            eoi_wr;
  logic [15:0]     rd;
  logic            unused_wd;

  assign pend     = irq_in & mask_q
                  & {NSRC{gen_q}};
  // Level of the source currently held in cpu_vec
  assign pend_sh  = pend >> vec_q;
  assign cur_live = pend_sh[0];

  assign ctrl_wr  = sel & we
                  & (addr == A_CTRL);
  assign eoi_wr   = sel & we
                  & (addr == A_EOI);

  assign arb_ptr  = (ARB_RR != 0)
                  ? ptr_q : '0;

  irq_arb #(
    .NSRC (NSRC),
    .VW   (VW)
  ) u_arb (
    .req         (pend),
    .ptr         (arb_ptr),
    .grant_valid (gnt_valid),
    .grant_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      vec_q  <= '0;
      ptr_q  <= '0;
      irq_q  <= 1'b0;
      gen_q  <= 1'b0;
      mask_q <= '0;
    end else begin
      st_q  <= st_nx;
      vec_q <= vec_nx;
      ptr_q <= ptr_nx;
      irq_q <= irq_nx;
      if (ctrl_wr) begin
        gen_q  <= wdata[GEN_BIT];
        mask_q <= wdata[NSRC-1:0];
      end
    end
  end

  always_comb begin
    st_nx  = st_q;
    vec_nx = vec_q;
    ptr_nx = ptr_q;
    irq_nx = irq_q;
    unique case (st_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          st_nx  = ST_REQ;
          vec_nx = gnt_idx;
          irq_nx = 1'b1;
        end
      end
      ST_REQ: begin
        // Ack beats a same-cycle withdrawal
        if (cpu_ack) begin
          st_nx  = ST_INSVC;
          irq_nx = 1'b0;
          if (ARB_RR != 0)
            ptr_nx = VW'(wrap_inc(
                       int'(vec_q), NSRC));
        end else if (!cur_live) begin
          st_nx  = ST_IDLE;
          irq_nx = 1'b0;
        end
      end
      ST_INSVC: begin
        irq_nx = 1'b0;
        if (eoi_wr)
          st_nx = ST_IDLE;
      end
      default: begin
        st_nx  = ST_IDLE;
        irq_nx = 1'b0;
      end
    endcase
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      (addr == A_CTRL): begin
        rd[NSRC-1:0] = mask_q;
        rd[GEN_BIT]  = gen_q;
      end
      (addr == A_PEND): begin
        rd[NSRC-1:0] = irq_in & mask_q;
      end
      (addr == A_STAT): begin
        rd[VW-1:0]    = vec_q;
        rd[INSVC_BIT] = (st_q == ST_INSVC);
        rd[9:8]       = st_q;
      end
      default: rd = '0;
    endcase
  end

  assign rdata   = (sel & re) ? rd : '0;
  assign rdy     = sel;
  assign cpu_irq = irq_q;
  assign cpu_vec = vec_q;

  // Only GEN and MASK bits of wdata are stored
  assign unused_wd = ^wdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: checks fixed and round-robin irq_ctrl
// instances with vector tables, sequences, random model.
module tb_irq_ctrl;

  localparam int NSRC = 4;
  localparam int VW   = 3;
  localparam int FULL = (1 << NSRC) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, sel, we, re, ack;
  logic [1:0]      addr;
  logic [15:0]     wdata;
  logic [NSRC-1:0] irq_in;
  logic [15:0]     rdata0, rdata1;
  logic            rdy0, rdy1, irq0, irq1;
  logic [VW-1:0]   vec0, vec1;

  irq_ctrl #(
    .NSRC(NSRC), .ARB_RR(0), .VW(VW)
  ) u_fix (
    .clk(clk), .rst_n(rst_n), .sel(sel),
    .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata0), .rdy(rdy0),
    .irq_in(irq_in), .cpu_irq(irq0),
    .cpu_vec(vec0), .cpu_ack(ack)
  );

  irq_ctrl #(
    .NSRC(NSRC), .ARB_RR(1), .VW(VW)
  ) u_rr (
    .clk(clk), .rst_n(rst_n), .sel(sel),
    .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata1), .rdy(rdy1),
    .irq_in(irq_in), .cpu_irq(irq1),
    .cpu_vec(vec1), .cpu_ack(ack)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(
    input string name,
    input int    act,
    input int    exp
  );
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  // Reference model, index 0 = fixed, 1 = round-robin.
  // st: 0 idle, 1 requesting, 2 in service.
  int m_st[2], m_vec[2], m_irq[2];
  int m_ptr[2], m_gen[2], m_mask[2];

  function automatic int winner(
    input int p,
    input int start
  );
    for (int i = 0; i < NSRC; i++) begin
      int j;
      j = (start + i) % NSRC;
      if (((p >> j) & 1) == 1)
        return j;
    end
    return 0;
  endfunction

  task automatic model_step();
    int  pend;
    bit  eoi, cw;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_st[k] = 0; m_vec[k] = 0;
        m_irq[k] = 0; m_ptr[k] = 0;
        m_gen[k] = 0; m_mask[k] = 0;
      end else begin
        pend = int'(irq_in) & m_mask[k]
             & ((m_gen[k] != 0) ? FULL : 0);
        eoi = sel && we && (addr == 2'd3);
        cw  = sel && we && (addr == 2'd0);
        case (m_st[k])
          0: if (pend != 0) begin
            m_vec[k] = winner(pend,
                         (k == 1) ? m_ptr[k] : 0);
            m_st[k]  = 1;
            m_irq[k] = 1;
          end
          1: if (ack) begin
            m_st[k]  = 2;
            m_irq[k] = 0;
            if (k == 1)
              m_ptr[k] = (m_vec[k] + 1) % NSRC;
          end else if (((pend >> m_vec[k]) & 1) == 0) begin
            m_st[k]  = 0;
            m_irq[k] = 0;
          end
          default: if (eoi) m_st[k] = 0;
        endcase
        if (cw) begin
          m_gen[k]  = int'(wdata[15]);
          m_mask[k] = int'(wdata) & FULL;
        end
      end
    end
  endtask

  function automatic int model_rd(input int k);
    if (!(sel && re)) return 0;
    case (addr)
      2'd0: return (m_gen[k] << 15) | m_mask[k];
      2'd1: return int'(irq_in) & m_mask[k];
      2'd2: return (m_st[k] << 8)
                 | ((m_st[k] == 2 ? 1 : 0) << 7)
                 | m_vec[k];
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    sel = 0; we = 0; re = 0; ack = 0;
    addr = 0; wdata = 0;
  endtask

  typedef struct {
    logic        rst_n, sel, we, re, ack;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [3:0]  irq;
    logic        e_irq;
    logic [2:0]  e_vec;
    logic [15:0] e_rd;
  } vec_t;

  function automatic vec_t mk(
    input logic r, s, w, rr, a,
    input logic [1:0]  ad,
    input logic [15:0] wd,
    input logic [3:0]  iq,
    input logic        ei,
    input logic [2:0]  ev,
    input logic [15:0] er
  );
    vec_t v;
    v.rst_n = r; v.sel = s; v.we = w;
    v.re = rr; v.ack = a; v.addr = ad;
    v.wdata = wd; v.irq = iq;
    v.e_irq = ei; v.e_vec = ev; v.e_rd = er;
    return v;
  endfunction

  localparam int NV = 33;
  vec_t tbl[NV];
  int   rr_exp[5];

  initial begin
    rst_n = 0; irq_in = 0;
    idle_in();

    // reset, readback
    tbl[0]  = mk(0,0,0,0,0,0,0,0,       0,0,0);
    tbl[1]  = mk(1,1,0,1,0,0,0,0,       0,0,0);
    tbl[2]  = mk(1,1,0,1,0,1,0,4'hF,    0,0,0);
    tbl[3]  = mk(1,1,0,1,0,2,0,0,       0,0,0);
    // single source handshake
    tbl[4]  = mk(1,1,1,1,0,0,16'h8001,0,0,0,16'h8001);
    tbl[5]  = mk(1,1,0,1,0,2,0,4'h1,    1,0,16'h0100);
    tbl[6]  = mk(1,1,0,1,1,2,0,4'h1,    0,0,16'h0280);
    tbl[7]  = mk(1,1,0,1,0,1,0,0,       0,0,0);
    tbl[8]  = mk(1,1,1,0,0,3,0,0,       0,0,0);
    tbl[9]  = mk(1,1,0,1,0,2,0,0,       0,0,0);
    // fixed priority
    tbl[10] = mk(1,1,1,1,0,0,16'h800F,0,0,0,16'h800F);
    tbl[11] = mk(1,1,0,1,0,1,0,4'hA,    1,1,16'h000A);
    tbl[12] = mk(1,1,0,1,1,2,0,4'hA,    0,1,16'h0281);
    tbl[13] = mk(1,1,1,0,0,3,0,4'h8,    0,1,0);
    tbl[14] = mk(1,1,0,1,0,2,0,4'h8,    1,3,16'h0103);
    tbl[15] = mk(1,0,0,0,1,0,0,4'h8,    0,3,0);
    // withdrawal, late ack ignored
    tbl[16] = mk(1,1,1,0,0,3,0,4'h4,    0,3,0);
    tbl[17] = mk(1,0,0,0,0,0,0,4'h4,    1,2,0);
    tbl[18] = mk(1,1,0,1,0,2,0,0,       0,2,16'h0002);
    tbl[19] = mk(1,1,0,1,1,2,0,0,       0,2,16'h0002);
    // ack + withdrawal same cycle; EOI in idle
    tbl[20] = mk(1,0,0,0,0,0,0,4'h1,    1,0,0);
    tbl[21] = mk(1,1,0,1,1,2,0,0,       0,0,16'h0280);
    tbl[22] = mk(1,1,1,0,0,3,0,0,       0,0,0);
    tbl[23] = mk(1,1,1,1,1,3,0,0,       0,0,0);
    tbl[24] = mk(1,1,0,1,0,2,0,0,       0,0,0);
    // reset while in service
    tbl[25] = mk(1,0,0,0,0,0,0,4'h4,    1,2,0);
    tbl[26] = mk(1,1,0,1,1,2,0,4'h4,    0,2,16'h0282);
    tbl[27] = mk(0,1,0,1,0,0,0,4'h4,    0,0,0);
    tbl[28] = mk(1,1,0,1,0,2,0,4'h4,    0,0,0);
    // GEN cleared while requesting
    tbl[29] = mk(1,1,1,1,0,0,16'h800F,4'h4,0,0,16'h800F);
    tbl[30] = mk(1,1,0,1,0,2,0,4'h4,    1,2,16'h0102);
    tbl[31] = mk(1,1,1,1,0,0,16'h000F,4'h4,1,2,16'h000F);
    tbl[32] = mk(1,1,0,1,0,2,0,4'h4,    0,2,16'h0002);

    rr_exp = '{0, 1, 2, 3, 0};

    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      rst_n  = tbl[i].rst_n;
      sel    = tbl[i].sel;
      we     = tbl[i].we;
      re     = tbl[i].re;
      ack    = tbl[i].ack;
      addr   = tbl[i].addr;
      wdata  = tbl[i].wdata;
      irq_in = tbl[i].irq;
      tick();
      chk($sformatf("tbl%0d_irq", i),
          int'(irq0), int'(tbl[i].e_irq));
      chk($sformatf("tbl%0d_vec", i),
          int'(vec0), int'(tbl[i].e_vec));
      chk($sformatf("tbl%0d_rdata", i),
          int'(rdata0), int'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_rdy", i),
          int'(rdy0), int'(tbl[i].sel));
    end

    // round-robin rotation with all sources held
    idle_in();
    rst_n = 0; irq_in = 0;
    tick();
    rst_n = 1; irq_in = 4'hF;
    sel = 1; we = 1; addr = 0;
    wdata = 16'h800F;
    tick();
    idle_in();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr%0d_irq", i),
          int'(irq1), 1);
      chk($sformatf("rr%0d_vec", i),
          int'(vec1), rr_exp[i]);
      chk($sformatf("fix%0d_vec", i),
          int'(vec0), 0);
      ack = 1;
      tick();
      ack = 0;
      chk($sformatf("rr%0d_ackirq", i),
          int'(irq1), 0);
      sel = 1; we = 1; addr = 3;
      tick();
      idle_in();
      tick();
    end

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom % 150) != 0;
      sel   = ($urandom % 3) != 0;
      we    = sel && (($urandom % 4) == 0);
      re    = ($urandom % 2) == 1;
      addr  = 2'($urandom);
      wdata = 16'($urandom);
      wdata[15] = ($urandom % 4) != 0;
      ack   = ($urandom % 3) == 0;
      if (($urandom % 6) == 0)
        irq_in = NSRC'($urandom);
      tick();
      chk($sformatf("rnd%0d_fix_irq", n),
          int'(irq0), m_irq[0]);
      chk($sformatf("rnd%0d_fix_vec", n),
          int'(vec0), m_vec[0]);
      chk($sformatf("rnd%0d_fix_rd", n),
          int'(rdata0), model_rd(0));
      chk($sformatf("rnd%0d_rr_irq", n),
          int'(irq1), m_irq[1]);
      chk($sformatf("rnd%0d_rr_vec", n),
          int'(vec1), m_vec[1]);
      chk($sformatf("rnd%0d_rr_rd", n),
          int'(rdata1), model_rd(1));
      chk($sformatf("rnd%0d_rdy", n),
          int'(rdy1), int'(sel));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
